// File: rtl/fetch_stage.sv
// fetch_stage: IF stage owning the 64-bit PC and the IF/ID register,
// with hazard stalls, EX-stage redirects and a halt at the end of the program image.
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 156,
    parameter logic [31:0] NOP_INSN   = 32'h00000013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [63:0] branch_target,
    output logic [63:0] inst_address,
    input  logic [31:0] instruction,
    output logic [63:0] if_id_pc,
    output logic [31:0] if_id_instruction,
    output logic        if_id_valid,
    output logic        halted
);
    typedef enum logic {RUN, HALT} state_t;
    localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES) - 64'd4;
    state_t      state, state_n;
    logic [63:0] pc, pc_n, if_id_pc_n;
    logic [31:0] if_id_instruction_n;
    logic        if_id_valid_n, run;
    assign run = state == RUN;
    assign inst_address = pc;
    assign halted = state == HALT;
    always_comb begin
        pc_n = pc;
        state_n = state;
        if_id_pc_n = if_id_pc;
        if_id_instruction_n = if_id_instruction;
        if_id_valid_n = if_id_valid;
        if (branch_taken) begin
            pc_n = {branch_target[63:2], 2'b00};
            if_id_pc_n = 64'd0;
            if_id_instruction_n = NOP_INSN;
            if_id_valid_n = 1'b0;
            // image size is word aligned, so the raw target compares the same as the aligned one
            state_n = branch_target < 64'(IMEM_BYTES) ? RUN : HALT;
        end else if (!stall) begin
            if_id_pc_n = run ? pc : 64'd0;
            if_id_instruction_n = run ? instruction : NOP_INSN;
            if_id_valid_n = run;
            state_n = run && pc == LAST_PC ? HALT : state;
            pc_n = run && pc != LAST_PC ? pc + 64'd4 : pc;
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
            state <= RUN;
            if_id_pc <= 64'd0;
            if_id_instruction <= NOP_INSN;
            if_id_valid <= 1'b0;
        end else begin
            pc <= pc_n;
            state <= state_n;
            if_id_pc <= if_id_pc_n;
            if_id_instruction <= if_id_instruction_n;
            if_id_valid <= if_id_valid_n;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios plus randomized stall/redirect traffic against a program-image model.
module tb_fetch_stage;
    localparam int IMEM = 156;
    localparam logic [31:0] NOP = 32'h00000013;
    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0;
    logic [63:0] branch_target = 64'd0, inst_address, if_id_pc;
    logic [31:0] instruction, if_id_instruction;
    logic        if_id_valid, halted;
    logic [31:0] mem [64];
    logic [63:0] m_pc, m_ipc;
    logic [31:0] m_ins;
    logic        m_val, m_halt;
    int tests = 0, fails = 0;

    fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .inst_address(inst_address),
        .instruction(instruction), .if_id_pc(if_id_pc),
        .if_id_instruction(if_id_instruction), .if_id_valid(if_id_valid), .halted(halted)
    );

    always #5 clk = ~clk;
    always_comb instruction = inst_address < 64'(IMEM) ? mem[inst_address[7:2]] : 32'hDEADBEEF;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".inst_address"}, inst_address, m_pc);
        chk({tag, ".if_id_pc"}, if_id_pc, m_ipc);
        chk({tag, ".if_id_instruction"}, 64'(if_id_instruction), 64'(m_ins));
        chk({tag, ".if_id_valid"}, 64'(if_id_valid), 64'(m_val));
        chk({tag, ".halted"}, 64'(halted), 64'(m_halt));
    endtask

    task automatic model_reset();
        m_pc = 64'd0; m_halt = 1'b0; m_ipc = 64'd0; m_ins = NOP; m_val = 1'b0;
    endtask

    // One clock: the model applies branch > stall > advance to the image, then the DUT is compared
    task automatic step(input logic b, input logic s, input logic [63:0] t, input string tag);
        logic [63:0] aligned;
        branch_taken = b; stall = s; branch_target = t;
        aligned = t & ~64'd3;
        if (b) begin
            m_pc = aligned; m_ipc = 64'd0; m_ins = NOP; m_val = 1'b0;
            m_halt = aligned >= 64'(IMEM);
        end else if (!s) begin
            if (m_halt) begin
                m_ipc = 64'd0; m_ins = NOP; m_val = 1'b0;
            end else begin
                m_ipc = m_pc; m_ins = mem[int'(m_pc / 4)]; m_val = 1'b1;
                if (m_pc + 4 == 64'(IMEM)) m_halt = 1'b1;
                else m_pc = m_pc + 4;
            end
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        mem[0] = 32'h00000513;
        mem[1] = 32'h00F00713;
        model_reset();
        #12 reset = 1'b0;
        check_all("reset");
        // 1: straight-line fetch
        step(0, 0, 0, "t1.c1");
        chk("t1.insn0", 64'(if_id_instruction), 64'h00000513);
        step(0, 0, 0, "t1.c2");
        chk("t1.pc1", if_id_pc, 64'd4);
        chk("t1.addr", inst_address, 64'd8);
        // 2: stall holds everything
        for (int i = 0; i < 3; i++) step(0, 1, 0, "t2.stall");
        chk("t2.hold_pc", if_id_pc, 64'd4);
        step(0, 0, 0, "t2.resume");
        chk("t2.ifid_pc", if_id_pc, 64'd8);
        chk("t2.addr", inst_address, 64'd12);
        // 3: redirect overrides stall
        while (m_pc != 64'd40) step(0, 0, 0, "t3.run");
        step(1, 1, 64'h23, "t3.branch");
        chk("t3.addr", inst_address, 64'h20);
        chk("t3.valid", 64'(if_id_valid), 64'd0);
        // 4: run off the end of the image
        for (int i = 0; i < 60 && !m_halt; i++) step(0, 0, 0, "t4.run");
        chk("t4.last_pc", if_id_pc, 64'd152);
        chk("t4.halted", 64'(halted), 64'd1);
        step(0, 0, 0, "t4.bubble1");
        step(0, 0, 0, "t4.bubble2");
        chk("t4.addr", inst_address, 64'd152);
        chk("t4.valid", 64'(if_id_valid), 64'd0);
        // 5: in-range redirect leaves HALT
        step(1, 0, 64'h10, "t5.branch");
        chk("t5.halted", 64'(halted), 64'd0);
        step(0, 0, 0, "t5.next");
        chk("t5.ifid_pc", if_id_pc, 64'd16);
        // 6: async reset mid-stall, then out-of-range redirect
        while (m_pc != 64'd96) step(0, 0, 0, "t6.run");
        step(0, 1, 0, "t6.stall");
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_all("t6.async_reset");
        #2 reset = 1'b0;
        step(1, 1, 64'd200, "t6.branch_oor");
        chk("t6.halted", 64'(halted), 64'd1);
        step(0, 0, 0, "t6.bubble");
        chk("t6.addr", inst_address, 64'd200);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic b, s;
            logic [63:0] t;
            b = $urandom_range(0, 7) == 0;
            s = $urandom_range(0, 3) == 0;
            t = $urandom_range(0, 9) == 0 ? {$urandom, $urandom} : 64'($urandom_range(0, 200));
            step(b, s, t, "rand");
        end
        branch_taken = 1'b0; stall = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
